// File: rtl/gru_seq_pkg.sv
// Shared types for the GRU sequencer: FSM states and the step-counter width.
package gru_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CELL,
    S_EMIT
  } state_t;

  // max(1, clog2(seq_len)); a single-step sequence still needs a 1-bit counter
  function automatic int step_width(input int seq_len);
    int w;
    w = $clog2(seq_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gru_hstate_reg.sv
// Hidden-state register feeding the cell's h_prev operand.
// Clear (reset or end of sequence) wins over load.
module gru_hstate_reg #(
  parameter int WIDTH  = 16,
  parameter int H_SIZE = 120
) (
  input  logic                           clk,
  input  logic                           clear,
  input  logic                           load,
  input  logic [H_SIZE-1:0][WIDTH-1:0]   d,
  output logic [H_SIZE-1:0][WIDTH-1:0]   q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/gru_seq_ctrl.sv
// Steps one GRU cell across an input sequence with valid/ready on both sides,
// start/done to the cell, and emission of the final (or every) hidden state.
module gru_seq_ctrl
  import gru_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int X_SIZE     = 6,
  parameter int H_SIZE     = 120,
  parameter int SEQ_LEN    = 15,
  parameter int RETURN_SEQ = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           x_valid,
  output logic                           x_ready,
  input  logic [X_SIZE-1:0][WIDTH-1:0]   x_data,
  input  logic                           x_last,
  output logic [X_SIZE-1:0][WIDTH-1:0]   cell_x,
  output logic [H_SIZE-1:0][WIDTH-1:0]   cell_h_prev,
  output logic                           cell_start,
  input  logic                           cell_done,
  input  logic [H_SIZE-1:0][WIDTH-1:0]   cell_h,
  output logic                           h_valid,
  input  logic                           h_ready,
  output logic [H_SIZE-1:0][WIDTH-1:0]   h_data,
  output logic                           h_last,
  output logic                           seq_err,
  output logic                           busy
);

  localparam int             SW        = step_width(SEQ_LEN);
  localparam logic [SW-1:0]  LAST_STEP = SW'(SEQ_LEN - 1);
  localparam bit             RET_ALL   = (RETURN_SEQ != 0);

  state_t        state, state_nxt;
  logic [SW-1:0] step;
  logic          is_last;
  logic          start_q;
  logic          accept, done_ok, out_fire;
  logic          at_last, emit;

  assign at_last = (step == LAST_STEP);
  assign emit    = is_last || RET_ALL;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    h_valid   = 1'b0;
    accept    = 1'b0;
    done_ok   = 1'b0;
    out_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        x_ready = !reset;
        if (x_valid && x_ready) begin
          accept    = 1'b1;
          state_nxt = S_CELL;
        end
      end
      // done may arrive together with the start pulse (zero-latency cell)
      S_CELL: begin
        if (cell_done) begin
          done_ok   = 1'b1;
          state_nxt = emit ? S_EMIT : S_IDLE;
        end
      end
      S_EMIT: begin
        h_valid = 1'b1;
        if (h_ready) begin
          out_fire  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step    <= '0;
      is_last <= 1'b0;
      start_q <= 1'b0;
      seq_err <= 1'b0;
      cell_x  <= '0;
      h_data  <= '0;
      h_last  <= 1'b0;
    end else begin
      start_q <= accept;
      // x_last disagreeing with the counter in either direction is flagged
      seq_err <= accept && (x_last != at_last);
      if (accept) begin
        cell_x  <= x_data;
        is_last <= x_last || at_last;
      end
      if (done_ok && emit) begin
        h_data <= cell_h;
        h_last <= is_last;
      end
      if (done_ok && !emit) begin
        step <= step + SW'(1);
      end
      if (out_fire) begin
        h_last <= 1'b0;
        step   <= h_last ? '0 : step + SW'(1);
      end
    end
  end

  assign cell_start = start_q;
  assign busy       = (state != S_IDLE) || (step != '0);

  gru_hstate_reg #(
    .WIDTH  (WIDTH),
    .H_SIZE (H_SIZE)
  ) u_hstate (
    .clk   (clk),
    .clear (reset || (out_fire && h_last)),
    .load  (done_ok),
    .d     (cell_h),
    .q     (cell_h_prev)
  );

endmodule
